// File: rtl/rx_sr.sv
// rx_sr: assembles NUM_WORDS input words into one block, shifting each word in MSW-first.
// Define RX_SR_DROP_ERR_EN to add the sticky drop_err output, set when clear flushes data.
//
// state   | meaning
// FILL    | collecting words, block_valid=0
// FULL    | complete block held on data_out, block_valid=1
module rx_sr #(
    parameter int WORD_BITS = 32,
    parameter int NUM_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           clear,
    input  logic [WORD_BITS-1:0]           data_in,
    input  logic                           word_valid,
    output logic                           word_ready,
    output logic [WORD_BITS*NUM_WORDS-1:0] data_out,
    output logic                           block_valid,
    input  logic                           block_ready,
    output logic [4:0]                     word_count
`ifdef RX_SR_DROP_ERR_EN
    ,
    output logic                           drop_err
`endif
);

    localparam int TOTAL_BITS = WORD_BITS * NUM_WORDS;
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;
    localparam logic [4:0] LAST_CNT = 5'(NUM_WORDS - 1);

    logic [0:0]            state;
    logic                  accept;
    logic [TOTAL_BITS-1:0] shifted;

    assign block_valid = (state == ST_FULL);
    assign word_ready  = !block_valid | block_ready;
    assign accept      = word_valid & word_ready;
    assign shifted     = {data_out[TOTAL_BITS-WORD_BITS-1:0], data_in};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_FILL;
            data_out   <= '0;
            word_count <= '0;
        end else if (clear) begin
            state      <= ST_FILL;
            data_out   <= '0;
            word_count <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        data_out <= shifted;
                        if (word_count == LAST_CNT) begin
                            word_count <= '0;
                            state      <= ST_FULL;
                        end else begin
                            word_count <= word_count + 5'd1;
                        end
                    end
                end
                default: begin
                    // Release and, if a word is waiting, take it as word 1 of the next block.
                    if (block_ready) begin
                        state <= ST_FILL;
                        if (word_valid) begin
                            data_out   <= shifted;
                            word_count <= 5'd1;
                        end else begin
                            word_count <= '0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef RX_SR_DROP_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_err <= 1'b0;
        end else if (clear && ((word_count != 5'd0) || block_valid)) begin
            drop_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_sr.sv
// Directed and randomized self-checking bench for rx_sr (WORD_BITS=32, NUM_WORDS=4).
module tb_rx_sr;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         clear = 1'b0;
    logic [31:0]  data_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready;
    logic [127:0] data_out;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic [4:0]   word_count;
`ifdef RX_SR_DROP_ERR_EN
    logic         drop_err;
`endif

    int errors = 0;
    int checks = 0;

    rx_sr #(.WORD_BITS(32), .NUM_WORDS(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .data_in    (data_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .data_out   (data_out),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .word_count (word_count)
`ifdef RX_SR_DROP_ERR_EN
        ,
        .drop_err   (drop_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        data_in    = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, data_out, 128'h0);
        check({tag, "_cnt"}, 128'(word_count), 128'd0);
        check({tag, "_bv"}, 128'(block_valid), 128'd0);
        check({tag, "_wr"}, 128'(word_ready), 128'd1);
    endtask

    logic [31:0]  q[$];
    logic [127:0] held;
    logic [127:0] exp_blk;
    logic         m_bv;
    int           m_cnt;
    int           blocks;
    int           cycles;
    logic         acc;

    initial begin
        // reset state
        #2;
        check_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // four consecutive words -> block
        push(32'h00112233);
        check("fill_cnt1", 128'(word_count), 128'd1);
        push(32'h44556677);
        check("fill_cnt2", 128'(word_count), 128'd2);
        push(32'h8899AABB);
        check("fill_cnt3", 128'(word_count), 128'd3);
        check("fill_bv0", 128'(block_valid), 128'd0);
        push(32'hCCDDEEFF);
        check("blk1_bv", 128'(block_valid), 128'd1);
        check("blk1_cnt", 128'(word_count), 128'd0);
        check("blk1_data", data_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // backpressure: held block, waiting word not lost
        held       = data_out;
        data_in    = 32'h11111111;
        word_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_wr0", 128'(word_ready), 128'd0);
            tick();
            check("bp_hold", data_out, held);
            check("bp_bv", 128'(block_valid), 128'd1);
        end
        block_ready = 1'b1;
        #1;
        check("bp_wr1", 128'(word_ready), 128'd1);
        tick();
        word_valid = 1'b0;
        check("bp_take_cnt", 128'(word_count), 128'd1);
        check("bp_take_bv", 128'(block_valid), 128'd0);
        // block_ready stays high during fill: must be ignored
        push(32'h22222222);
        push(32'h33333333);
        push(32'h44444444);
        check("blk2_data", data_out, 128'h11111111_22222222_33333333_44444444);
        check("blk2_bv", 128'(block_valid), 128'd1);

        // release and accept on same edge
        push(32'hDEADBEEF);
        check("rel_cnt", 128'(word_count), 128'd1);
        check("rel_bv", 128'(block_valid), 128'd0);
        push(32'hA1A1A1A1);
        push(32'hA2A2A2A2);
        push(32'hA3A3A3A3);
        check("blk3_top", 128'(data_out[127:96]), 128'hDEADBEEF);
        check("blk3_data", data_out, 128'hDEADBEEF_A1A1A1A1_A2A2A2A2_A3A3A3A3);

        // release with no word waiting
        tick();
        check("rel_idle_bv", 128'(block_valid), 128'd0);
        check("rel_idle_cnt", 128'(word_count), 128'd0);

        // clear after 2 words
        push(32'h12345678);
        push(32'h9ABCDEF0);
        clear      = 1'b1;
        data_in    = 32'h55555555;
        word_valid = 1'b1;
        tick();
        clear      = 1'b0;
        word_valid = 1'b0;
        check_zero("clear");
`ifdef RX_SR_DROP_ERR_EN
        check("drop_set", 128'(drop_err), 128'd1);
`endif
        push(32'h0000000A);
        push(32'h0000000B);
        push(32'h0000000C);
        push(32'h0000000D);
        check("blk4_data", data_out, 128'h0000000A_0000000B_0000000C_0000000D);
`ifdef RX_SR_DROP_ERR_EN
        check("drop_sticky", 128'(drop_err), 128'd1);
`endif
        tick();

        // async reset after 3 words
        push(32'hF0000001);
        push(32'hF0000002);
        push(32'hF0000003);
        #2;
        n_rst = 1'b0;
        #1;
        check_zero("rst_mid");
`ifdef RX_SR_DROP_ERR_EN
        check("rst_drop", 128'(drop_err), 128'd0);
`endif
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        push(32'hE0000001);
        push(32'hE0000002);
        push(32'hE0000003);
        check("rst_cnt3", 128'(word_count), 128'd3);
        push(32'hE0000004);
        check("blk5_data", data_out, 128'hE0000001_E0000002_E0000003_E0000004);

        // throughput: block_ready high, back-to-back words
        push(32'hB0000001);
        check("tp_cnt1", 128'(word_count), 128'd1);
        push(32'hB0000002);
        push(32'hB0000003);
        push(32'hB0000004);
        check("tp_bv_a", 128'(block_valid), 128'd1);
        check("tp_blk_a", data_out, 128'hB0000001_B0000002_B0000003_B0000004);
        push(32'hC0000001);
        push(32'hC0000002);
        push(32'hC0000003);
        push(32'hC0000004);
        check("tp_bv_b", 128'(block_valid), 128'd1);
        check("tp_blk_b", data_out, 128'hC0000001_C0000002_C0000003_C0000004);

        // random valid/ready against a reference queue
        #2;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        m_bv   = 1'b0;
        m_cnt  = 0;
        blocks = 0;
        cycles = 0;
        while (blocks < 1000 && cycles < 40000) begin
            word_valid  = ($urandom_range(0, 3) != 0);
            block_ready = $urandom_range(0, 1) != 0;
            data_in     = $urandom;
            #1;
            check("rnd_bv", 128'(block_valid), 128'(m_bv));
            check("rnd_wr", 128'(word_ready), 128'(!m_bv || block_ready));
            acc = word_valid && (!m_bv || block_ready);
            if (m_bv && block_ready) begin
                exp_blk = {q[0], q[1], q[2], q[3]};
                check("rnd_blk", data_out, exp_blk);
                for (int k = 0; k < 4; k++) void'(q.pop_front());
                blocks++;
                m_bv  = 1'b0;
                m_cnt = word_valid ? 1 : 0;
            end else if (!m_bv && word_valid) begin
                m_cnt++;
                if (m_cnt == 4) begin
                    m_cnt = 0;
                    m_bv  = 1'b1;
                end
            end
            if (acc) q.push_back(data_in);
            tick();
            check("rnd_cnt", 128'(word_count), 128'(m_cnt));
            cycles++;
        end
        check("rnd_blocks", 128'(blocks), 128'd1000);
        word_valid  = 1'b0;
        block_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
